// File: rtl/branch_pkg.sv
// Shared types and constants for the branch redirect controller.
//   pc_sel_t      : PC mux select encoding driven on pc_sel
//   redir_state_t : redirect sequencer states
//   FLUSH_CNT_W   : width of the post-redirect flush counter
package branch_pkg;

  localparam int unsigned FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_JALR   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JAL    = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } redir_state_t;

endpackage

// File: rtl/branch_redirect_ctrl_sel.sv
// Combinational redirect selection for the EX-stage instruction.
// Applies jal > jalr > branch priority, clears jalr target bit 0 and
// flags targets that are not 4-byte aligned.
// Ports:
//   ex_valid_i, ex_is_*_i, br_taken_i : EX decode / compare flags
//   *_tgt_i                           : candidate targets
//   req_c_o      : EX instruction requests a redirect
//   misalign_c_o : selected target is not 4-byte aligned
//   tgt_c_o      : selected target
//   code_c_o     : pc_sel code for the selected target
module redirect_sel
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jal_i,
  input  logic            ex_is_jalr_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] branch_tgt_i,
  input  logic [XLEN-1:0] jal_tgt_i,
  input  logic [XLEN-1:0] jalr_tgt_i,
  output logic            req_c_o,
  output logic            misalign_c_o,
  output logic [XLEN-1:0] tgt_c_o,
  output pc_sel_t         code_c_o
);

  logic [XLEN-1:0] jalr_clr;

  // jalr ignores bit 0 of the computed address
  assign jalr_clr = {jalr_tgt_i[XLEN-1:1], 1'b0};

  // Priority select; misalignment is judged on the final target
  always_comb begin
    req_c_o  = 1'b0;
    tgt_c_o  = '0;
    code_c_o = PC_PLUS4;
    if (ex_valid_i) begin
      if (ex_is_jal_i) begin
        req_c_o  = 1'b1;
        tgt_c_o  = jal_tgt_i;
        code_c_o = PC_JAL;
      end else if (ex_is_jalr_i) begin
        req_c_o  = 1'b1;
        tgt_c_o  = jalr_clr;
        code_c_o = PC_JALR;
      end else if (ex_is_branch_i && br_taken_i) begin
        req_c_o  = 1'b1;
        tgt_c_o  = branch_tgt_i;
        code_c_o = PC_BRANCH;
      end
    end
    misalign_c_o = req_c_o && (tgt_c_o[1:0] != 2'b00);
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch / jump redirect sequencer between EX and the front end.
// Registers the next-PC select and target, pulses pc_redirect, holds a
// redirect across stalls and keeps the front-end flushes asserted for
// FLUSH_CYCLES cycles. Every output appears one cycle after its cause.
// Ports:
//   CLK, RST_N                 : clock, synchronous active-low reset
//   ex_*, br_taken, *_tgt      : EX-stage control-flow information
//   stall                      : pipeline stall
//   pc_sel, redirect_pc        : PC mux select and redirect target
//   pc_redirect, misalign_exc  : one-cycle pulses
//   flush_if_id, flush_id_ex   : front-end kill
//   busy                       : controller in HOLD or FLUSH
// Build option BRANCH_PERF_CNT_EN adds perf_redirects, perf_br_taken and
// perf_misalign event counters.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            br_taken,
  input  logic [XLEN-1:0] branch_tgt,
  input  logic [XLEN-1:0] jal_tgt,
  input  logic [XLEN-1:0] jalr_tgt,
  input  logic            stall,
  output logic [1:0]      pc_sel,
  output logic [XLEN-1:0] redirect_pc,
  output logic            pc_redirect,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            misalign_exc,
  output logic            busy
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_br_taken,
  output logic [31:0]     perf_misalign
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  logic            sel_req;
  logic            sel_mis;
  logic [XLEN-1:0] sel_tgt;
  pc_sel_t         sel_code;

  redir_state_t           state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]        hold_tgt_q, hold_tgt_d;
  pc_sel_t                hold_sel_q, hold_sel_d;
  pc_sel_t                pc_sel_q, pc_sel_d;
  logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
  logic                   pc_redirect_q, pc_redirect_d;
  logic                   flush_q, flush_d;
  logic                   misalign_q, misalign_d;
  logic                   busy_q, busy_d;

  logic                   issue;
  logic [XLEN-1:0]        issue_tgt;
  pc_sel_t                issue_sel;

  redirect_sel #(.XLEN(XLEN)) u_sel (
    .ex_valid_i     (ex_valid),
    .ex_is_branch_i (ex_is_branch),
    .ex_is_jal_i    (ex_is_jal),
    .ex_is_jalr_i   (ex_is_jalr),
    .br_taken_i     (br_taken),
    .branch_tgt_i   (branch_tgt),
    .jal_tgt_i      (jal_tgt),
    .jalr_tgt_i     (jalr_tgt),
    .req_c_o        (sel_req),
    .misalign_c_o   (sel_mis),
    .tgt_c_o        (sel_tgt),
    .code_c_o       (sel_code)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_tgt_d    = hold_tgt_q;
    hold_sel_d    = hold_sel_q;
    pc_sel_d      = PC_PLUS4;
    redirect_pc_d = redirect_pc_q;
    pc_redirect_d = 1'b0;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    busy_d        = 1'b0;
    issue         = 1'b0;
    issue_tgt     = sel_tgt;
    issue_sel     = sel_code;

    unique case (state_q)
      RUN: begin
        if (sel_req) begin
          if (sel_mis) begin
            misalign_d = 1'b1;
          end else if (stall) begin
            hold_tgt_d = sel_tgt;
            hold_sel_d = sel_code;
            state_d    = HOLD;
          end else begin
            issue = 1'b1;
          end
        end
      end
      HOLD: begin
        // EX is frozen on the latched instruction; only stall matters
        if (stall) begin
          busy_d = 1'b1;
        end else begin
          issue     = 1'b1;
          issue_tgt = hold_tgt_q;
          issue_sel = hold_sel_q;
        end
      end
      FLUSH: begin
        // Wrong-path EX requests and stall are both ignored here
        busy_d  = 1'b1;
        flush_d = 1'b1;
        cnt_d   = cnt_q - FLUSH_CNT_W'(1);
        if (cnt_q <= FLUSH_CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (issue) begin
      pc_redirect_d = 1'b1;
      redirect_pc_d = issue_tgt;
      pc_sel_d      = issue_sel;
      flush_d       = 1'b1;
      if (FLUSH_INIT != '0) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_INIT;
      end else begin
        state_d = RUN;
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      hold_tgt_q    <= '0;
      hold_sel_q    <= PC_PLUS4;
      pc_sel_q      <= PC_PLUS4;
      redirect_pc_q <= '0;
      pc_redirect_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_tgt_q    <= hold_tgt_d;
      hold_sel_q    <= hold_sel_d;
      pc_sel_q      <= pc_sel_d;
      redirect_pc_q <= redirect_pc_d;
      pc_redirect_q <= pc_redirect_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      busy_q        <= busy_d;
    end
  end

  assign pc_sel       = pc_sel_q;
  assign redirect_pc  = redirect_pc_q;
  assign pc_redirect  = pc_redirect_q;
  assign flush_if_id  = flush_q;
  assign flush_id_ex  = flush_q;
  assign misalign_exc = misalign_q;
  assign busy         = busy_q;

`ifdef BRANCH_PERF_CNT_EN
  localparam int unsigned PERF_W = 32;

  logic [PERF_W-1:0] perf_redir_q, perf_br_q, perf_mis_q;
  logic              br_taken_evt;

  // A taken branch counts when the controller actually accepts it from EX
  assign br_taken_evt = (state_q == RUN) && sel_req && (sel_code == PC_BRANCH);

  // Event counters, wrapping naturally
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      perf_redir_q <= '0;
      perf_br_q    <= '0;
      perf_mis_q   <= '0;
    end else begin
      perf_redir_q <= perf_redir_q + PERF_W'(pc_redirect_d);
      perf_br_q    <= perf_br_q + PERF_W'(br_taken_evt);
      perf_mis_q   <= perf_mis_q + PERF_W'(misalign_d);
    end
  end

  assign perf_redirects = perf_redir_q;
  assign perf_br_taken  = perf_br_q;
  assign perf_misalign  = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios followed
// by random traffic, all outputs compared every cycle to a cycle-level model.
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FLUSH = 2;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, br_taken, stall;
  logic [XLEN-1:0] branch_tgt, jal_tgt, jalr_tgt;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] redirect_pc;
  logic            pc_redirect, flush_if_id, flush_id_ex, misalign_exc, busy;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model state: pending held redirect and remaining post-pulse flush cycles
  bit          m_hold;
  int          m_hold_code;
  logic [31:0] m_hold_tgt;
  int          m_flush_rem;
  // Expected outputs for the next cycle
  int          e_sel;
  logic [31:0] e_rpc;
  bit          e_pulse, e_flush, e_mis, e_busy;

  branch_redirect_ctrl #(.FLUSH_CYCLES(FLUSH), .XLEN(XLEN)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_is_jal    (ex_is_jal),
    .ex_is_jalr   (ex_is_jalr),
    .br_taken     (br_taken),
    .branch_tgt   (branch_tgt),
    .jal_tgt      (jal_tgt),
    .jalr_tgt     (jalr_tgt),
    .stall        (stall),
    .pc_sel       (pc_sel),
    .redirect_pc  (redirect_pc),
    .pc_redirect  (pc_redirect),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .misalign_exc (misalign_exc),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic issue(input int code, input logic [31:0] tgt);
    e_pulse     = 1'b1;
    e_flush     = 1'b1;
    e_sel       = code;
    e_rpc       = tgt;
    m_flush_rem = FLUSH - 1;
  endtask

  // Expected behaviour of the coming rising edge, given the inputs just driven
  task automatic model_step();
    int          code;
    logic [31:0] tgt;
    bit          req;
    e_sel = 0; e_pulse = 0; e_flush = 0; e_mis = 0; e_busy = 0;
    if (!RST_N) begin
      e_rpc = 0; m_hold = 0; m_hold_code = 0; m_hold_tgt = 0; m_flush_rem = 0;
    end else if (m_flush_rem > 0) begin
      e_flush = 1; e_busy = 1;
      m_flush_rem--;
    end else if (m_hold) begin
      if (stall) e_busy = 1;
      else begin
        issue(m_hold_code, m_hold_tgt);
        m_hold = 0;
      end
    end else begin
      req = 1'b0; code = 0; tgt = 0;
      if (ex_valid && ex_is_jal) begin
        req = 1; code = 3; tgt = jal_tgt;
      end else if (ex_valid && ex_is_jalr) begin
        req = 1; code = 1; tgt = jalr_tgt - (jalr_tgt % 2);
      end else if (ex_valid && ex_is_branch && br_taken) begin
        req = 1; code = 2; tgt = branch_tgt;
      end
      if (req) begin
        if (tgt % 4 != 0) e_mis = 1;
        else if (stall) begin
          m_hold = 1; m_hold_code = code; m_hold_tgt = tgt;
        end else issue(code, tgt);
      end
    end
  endtask

  // One cycle: check last edge's outputs, drive new inputs, predict next edge
  task automatic step(input logic rst, input logic v, input logic b, input logic j,
                      input logic jr, input logic tk, input logic [31:0] bt,
                      input logic [31:0] jt, input logic [31:0] jrt, input logic st);
    @(negedge CLK);
    if (check_en) begin
      check("pc_sel", 64'(pc_sel), 64'(e_sel));
      check("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
      check("pc_redirect", 64'(pc_redirect), 64'(e_pulse));
      check("flush_if_id", 64'(flush_if_id), 64'(e_flush));
      check("flush_id_ex", 64'(flush_id_ex), 64'(e_flush));
      check("misalign_exc", 64'(misalign_exc), 64'(e_mis));
      check("busy", 64'(busy), 64'(e_busy));
    end
    RST_N = rst; ex_valid = v; ex_is_branch = b; ex_is_jal = j; ex_is_jalr = jr;
    br_taken = tk; branch_tgt = bt; jal_tgt = jt; jalr_tgt = jrt; stall = st;
    model_step();
    check_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] bt, jt, jrt;
    m_hold = 0; m_hold_code = 0; m_hold_tgt = 0; m_flush_rem = 0; e_rpc = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Taken branch, no stall
    step(1, 1, 1, 0, 0, 1, 32'h100, 0, 0, 0);
    idle(4);
    // jalr aligned after bit0 clear, then misaligned jalr
    step(1, 1, 0, 0, 1, 0, 0, 0, 32'h2005, 0);
    idle(3);
    step(1, 1, 0, 0, 1, 0, 0, 0, 32'h2006, 0);
    idle(3);
    // jal held across a 3-cycle stall
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0, 0, 32'h400, 0, 1);
    idle(4);
    // Not-taken branch, then a second taken branch during FLUSH
    step(1, 1, 1, 0, 0, 0, 32'h800, 0, 0, 0);
    idle(2);
    step(1, 1, 1, 0, 0, 1, 32'h900, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 32'hA00, 0, 0, 0);
    idle(4);
    // Priority with all flags set
    step(1, 1, 1, 1, 1, 1, 32'h10, 32'h20, 32'h30, 0);
    idle(3);
    // Reset while holding: pending redirect is dropped
    step(1, 1, 0, 1, 0, 0, 0, 32'h440, 0, 1);
    step(1, 1, 0, 1, 0, 0, 0, 32'h440, 0, 1);
    step(0, 1, 0, 1, 0, 0, 0, 32'h440, 0, 1);
    idle(4);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bt = $urandom; jt = $urandom; jrt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jrt[1] = 1'b0;
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)),
           bt, jt, jrt,
           1'($urandom_range(0, 2) == 0));
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
